ysyx_25020037_issue_ctrl: RTL and testbench
===========================================

# ysyx_25020037_issue_ctrl

Issue controller and register scoreboard between the decode stage and the execute stage of the ysyx_25020037 core. It tracks every GPR write still in flight and stalls decode-to-execute issue on RAW/WAW hazards or when in-flight capacity is exhausted. It serializes fence.i / ecall / mret / CSR instructions by draining the pipeline before they issue and blocking all issue until they retire.

## Interface
Parameters:
- NR_REG, 16, number of tracked GPRs; only the low log2(NR_REG) bits of register indices are used.
- CNT_W, 2, width of each per-register pending-write counter; maximum count is 2^CNT_W-1.
- MAX_INFLIGHT, 4, maximum issued-but-not-retired instructions.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-high.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  decode may hand off this cycle.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1 / rs2.
- id_gpr_we  in  1  instruction writes rd.
- id_serial  in  1  fence.i, ecall, mret, csrrw or csrrs.
- ex_valid  out  1  instruction issued to execute.
- ex_ready  in  1  execute can accept.
- wb_valid  in  1  one instruction retires (exactly one pulse per issued instruction).
- wb_rd  in  5  retiring rd.
- wb_gpr_we  in  1  retiring instruction wrote rd.
- inflight  out  clog2(MAX_INFLIGHT+1)  current in-flight count.
- busy  out  1  state != RUN or inflight != 0.
- sb_err  out  1  sticky error flag.

## Operation
- Issue rule: fire = id_valid & ex_ready & ~stall; ex_valid = id_valid & ~stall; id_ready = ex_ready & ~stall.
- stall = hazard | (inflight == MAX_INFLIGHT) | (state != RUN) | (id_serial & inflight != 0).
- hazard = (id_use_rs1 & rs1!=0 & cnt[rs1]!=0) | (id_use_rs2 & rs2!=0 & cnt[rs2]!=0) | (id_gpr_we & rd!=0 & cnt[rd]==max).
- x0 is never tracked: writes to index 0 leave counters unchanged, and reads of index 0 never stall.
- Counters:
  - on fire with id_gpr_we and rd!=0, cnt[rd]+1;
  - on wb_valid with wb_gpr_we and wb_rd!=0, cnt[wb_rd]-1;
  - when both hit the same register in one cycle, the counter is unchanged.
- inflight: +1 on fire, -1 on wb_valid, unchanged when both occur.
- FSM states RUN, DRAIN, SOLO:
  - RUN -> SOLO when fire & id_serial.
  - RUN -> DRAIN when id_valid & id_serial & inflight != 0.
  - DRAIN -> RUN when inflight == 0; the serial instruction is re-evaluated next cycle.
  - SOLO -> RUN on wb_valid, which is the retirement of the serial instruction.
- sb_err sets and holds until rst on any of:
  - wb_valid while inflight == 0;
  - counter decrement while cnt == 0;
  - wb_valid while cnt[wb_rd] is 0 and wb_gpr_we is set.
- On an error the offending counter does not wrap; it stays 0.

## Timing
- Zero-cycle issue: ex_valid and id_ready are combinational from inputs plus registered state.
- Stall decisions use registered counters only. A retire that clears a hazard unblocks issue the following cycle; there is no same-cycle bypass.
- Reset values:
  - state RUN, all cnt 0, inflight 0, sb_err 0, busy 0;
  - ex_valid 0 while id_valid 0;
  - id_ready equals ex_ready when idle.
- rst asserted mid-operation discards all tracking in one cycle. Any subsequent wb_valid from pre-reset instructions sets sb_err, so the pipeline must be reset together with this block.
- A serial instruction takes at least 2 cycles beyond the drain: the issue cycle plus at least one SOLO cycle.

## Structure
- Shared package/header ysyx_25020037_config.vh holds:
  - FSM state encodings ISSUE_RUN, ISSUE_DRAIN, ISSUE_SOLO;
  - the register index width;
  - defaults for CNT_W and MAX_INFLIGHT.
- One natural sub-module, ysyx_25020037_sb_cnt: a per-register up/down saturating counter with an error output, instantiated NR_REG-1 times (index 0 omitted).

## Test plan
- RAW stall: issue addi x5 (gpr_we), then add x6,x5,x1 next cycle.
  - Expect ex_valid=0 until wb_valid for x5.
  - Expect the add to issue exactly the cycle after the retire, and cnt[5] back to 0.
- Capacity: 4 back-to-back independent writes to x1..x4 with no retire.
  - The 5th is stalled and inflight=4.
  - One wb_valid gives inflight=3, and the 5th issues next cycle.
- Serialize: 2 in flight, then csrrw arrives.
  - State goes to DRAIN and ex_valid stays 0.
  - After 2 retires the csrrw issues and state goes to SOLO.
  - A following addi stalls until the csrrw retires, then state is RUN.
- Simultaneous events: fire of a write to x7 in the same cycle as a retire of x7 with cnt[7]=1.
  - cnt[7] stays 1 and inflight is unchanged.
- x0 and saturation:
  - Writes to x0 never stall and never count.
  - With CNT_W=2, a 4th pending write to x3 stalls.
- Errors and reset: wb_valid with inflight=0 sets sb_err=1 and it holds; rst then clears everything to reset values.

Source files
------------

// File: rtl/ysyx_25020037_issue_ctrl_pkg.sv
// Shared configuration for the issue controller: FSM encodings, register
// index width and default sizing.
package ysyx_25020037_issue_ctrl_pkg;
   localparam int REG_IDX_W        = 5;
   localparam int CNT_W_DEF        = 2;
   localparam int MAX_INFLIGHT_DEF = 4;

   typedef enum logic [1:0] {
      ISSUE_RUN   = 2'd0,
      ISSUE_DRAIN = 2'd1,
      ISSUE_SOLO  = 2'd2
   } issue_state_e;
endpackage

// File: rtl/ysyx_25020037_sb_cnt.sv
// Pending-write counter for one GPR: up on issue, down on retire, never wraps.
// err flags a retire against a register with no pending write.
module ysyx_25020037_sb_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      err   = dec & (cnt_q == '0);
      if (inc & ~dec) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (dec & ~inc) begin
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/ysyx_25020037_issue_ctrl.sv
// Decode-to-execute issue controller with a GPR write scoreboard; stalls on
// RAW/WAW hazards and capacity, and runs serializing instructions alone.
module ysyx_25020037_issue_ctrl
   import ysyx_25020037_issue_ctrl_pkg::*;
#(
   parameter int NR_REG       = 16,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              id_valid,
   output logic                              id_ready,
   input  logic [REG_IDX_W-1:0]              id_rs1,
   input  logic [REG_IDX_W-1:0]              id_rs2,
   input  logic [REG_IDX_W-1:0]              id_rd,
   input  logic                              id_use_rs1,
   input  logic                              id_use_rs2,
   input  logic                              id_gpr_we,
   input  logic                              id_serial,
   output logic                              ex_valid,
   input  logic                              ex_ready,
   input  logic                              wb_valid,
   input  logic [REG_IDX_W-1:0]              wb_rd,
   input  logic                              wb_gpr_we,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
   output logic                              busy,
   output logic                              sb_err
);
   localparam int IDX_W = $clog2(NR_REG);
   localparam int IF_W  = $clog2(MAX_INFLIGHT+1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   issue_state_e state_q, state_d;
   logic [IF_W-1:0] inflight_q, inflight_d;
   logic            err_q, err_d;

   logic [IDX_W-1:0] rs1_i, rs2_i, rd_i, wb_rd_i;
   logic [NR_REG-1:0][CNT_W-1:0] cnt_all;
   logic [NR_REG-1:0] err_vec;
   logic hazard, stall, fire;

   assign rs1_i   = id_rs1[IDX_W-1:0];
   assign rs2_i   = id_rs2[IDX_W-1:0];
   assign rd_i    = id_rd[IDX_W-1:0];
   assign wb_rd_i = wb_rd[IDX_W-1:0];

   generate
      if (IDX_W < REG_IDX_W) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^{id_rs1[REG_IDX_W-1:IDX_W], id_rs2[REG_IDX_W-1:IDX_W],
                              id_rd[REG_IDX_W-1:IDX_W], wb_rd[REG_IDX_W-1:IDX_W]};
      end
   endgenerate

   // x0 has no counter: it reads as zero pending writes forever.
   assign cnt_all[0] = '0;
   assign err_vec[0] = 1'b0;

   generate
      for (genvar i = 1; i < NR_REG; i++) begin : g_cnt
         logic inc, dec;
         assign inc = fire & id_gpr_we & (rd_i == IDX_W'(i));
         assign dec = wb_valid & wb_gpr_we & (wb_rd_i == IDX_W'(i));
         ysyx_25020037_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc),
            .dec (dec),
            .cnt (cnt_all[i]),
            .err (err_vec[i])
         );
      end
   endgenerate

   always_comb begin
      hazard = (id_use_rs1 & (rs1_i != '0) & (cnt_all[rs1_i] != '0))
             | (id_use_rs2 & (rs2_i != '0) & (cnt_all[rs2_i] != '0))
             | (id_gpr_we  & (rd_i  != '0) & (cnt_all[rd_i] == CNT_MAX));
      stall  = hazard
             | (inflight_q == IF_W'(MAX_INFLIGHT))
             | (state_q != ISSUE_RUN)
             | (id_serial & (inflight_q != '0));
      fire   = id_valid & ex_ready & ~stall;
   end

   always_comb begin
      inflight_d = inflight_q;
      if (fire & ~wb_valid)
         inflight_d = inflight_q + 1'b1;
      else if (~fire & wb_valid & (inflight_q != '0))
         inflight_d = inflight_q - 1'b1;

      err_d = err_q | (wb_valid & (inflight_q == '0)) | (|err_vec);

      state_d = state_q;
      case (state_q)
         ISSUE_RUN: begin
            if (fire & id_serial)
               state_d = ISSUE_SOLO;
            else if (id_valid & id_serial & (inflight_q != '0))
               state_d = ISSUE_DRAIN;
         end
         // Leave DRAIN first; the serial op re-arbitrates from RUN next cycle.
         ISSUE_DRAIN: if (inflight_q == '0) state_d = ISSUE_RUN;
         ISSUE_SOLO:  if (wb_valid) state_d = ISSUE_RUN;
         default:     state_d = ISSUE_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ISSUE_RUN;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign ex_valid = id_valid & ~stall;
   assign id_ready = ex_ready & ~stall;
   assign inflight = inflight_q;
   assign busy     = (state_q != ISSUE_RUN) | (inflight_q != '0);
   assign sb_err   = err_q;
endmodule

// File: tb/tb_ysyx_25020037_issue_ctrl.sv
// Bench for the issue controller: directed scenarios plus randomized traffic
// checked against an in-order queue/array reference model.
module tb_ysyx_25020037_issue_ctrl;
   import ysyx_25020037_issue_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_ready, id_use_rs1, id_use_rs2, id_gpr_we, id_serial;
   logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic ex_valid, ex_ready, wb_valid, wb_gpr_we, busy, sb_err;
   logic [2:0] inflight;

   ysyx_25020037_issue_ctrl #(.NR_REG(16), .CNT_W(2), .MAX_INFLIGHT(4)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_gpr_we(id_gpr_we), .id_serial(id_serial),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_gpr_we(wb_gpr_we),
      .inflight(inflight), .busy(busy), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: pending-write counts, issued-instruction queue, mode.
   typedef struct { int rd; bit we; } ent_t;
   ent_t q[$];
   int   m_cnt[16];
   int   m_infl;
   int   m_mode;   // 0 run, 1 waiting for drain, 2 serial op alone
   bit   m_err;

   function automatic bit m_stall();
      int a = int'(id_rs1[3:0]);
      int b = int'(id_rs2[3:0]);
      int d = int'(id_rd[3:0]);
      bit hz = (id_use_rs1 && a != 0 && m_cnt[a] != 0) ||
               (id_use_rs2 && b != 0 && m_cnt[b] != 0) ||
               (id_gpr_we  && d != 0 && m_cnt[d] == 3);
      return hz || m_infl == 4 || m_mode != 0 || (id_serial && m_infl != 0);
   endfunction

   function automatic issue_state_e m_state();
      return (m_mode == 0) ? ISSUE_RUN : (m_mode == 1) ? ISSUE_DRAIN : ISSUE_SOLO;
   endfunction

   task automatic tick();
      bit fire;
      int n;
      int d = int'(id_rd[3:0]);
      int w = int'(wb_rd[3:0]);
      if (rst) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_infl = 0; m_mode = 0; m_err = 0; q.delete();
      end else begin
         fire = id_valid && ex_ready && !m_stall();
         case (m_mode)
            0: if (fire && id_serial) m_mode = 2;
               else if (id_valid && id_serial && m_infl != 0) m_mode = 1;
            1: if (m_infl == 0) m_mode = 0;
            default: if (wb_valid) m_mode = 0;
         endcase
         if (wb_valid && m_infl == 0) m_err = 1;
         if (wb_valid && wb_gpr_we && w != 0 && m_cnt[w] == 0) m_err = 1;
         if (fire && id_gpr_we && d != 0) m_cnt[d] = m_cnt[d] + 1;
         if (wb_valid && wb_gpr_we && w != 0) m_cnt[w] = m_cnt[w] - 1;
         foreach (m_cnt[i]) if (m_cnt[i] < 0) m_cnt[i] = 0;
         n = m_infl + (fire ? 1 : 0) - (wb_valid ? 1 : 0);
         m_infl = (n < 0) ? 0 : n;
         if (wb_valid && q.size() != 0) void'(q.pop_front());
         if (fire) q.push_back('{rd: d, we: id_gpr_we});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_gpr_we = 0; id_serial = 0;
      ex_ready = 1; wb_valid = 0; wb_rd = 0; wb_gpr_we = 0;
   endtask

   task automatic set_id(input int rd, input int rs1, input bit u1, input int rs2,
                         input bit u2, input bit we, input bit ser);
      id_valid = 1; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_use_rs1 = u1;
      id_rs2 = 5'(rs2); id_use_rs2 = u2; id_gpr_we = we; id_serial = ser;
   endtask

   task automatic set_wb_front();
      if (q.size() != 0) begin
         wb_valid = 1; wb_rd = 5'(q[0].rd); wb_gpr_we = q[0].we;
      end else wb_valid = 0;
   endtask

   task automatic drain_all();
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
         id_valid = 0; set_wb_front(); tick();
      end
      idle();
   endtask

   task automatic test_reset();
      idle(); rst = 1; tick(); rst = 0; #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got=%0b exp=1", id_ready); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got=%0b exp=0", sb_err); end
      ex_ready = 0; #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready_low got=%0b exp=0", id_ready); end
      ex_ready = 1;
   endtask

   task automatic test_raw();
      idle(); set_id(5, 0, 1, 0, 0, 1, 0); #1;
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL raw_first got=%0b exp=1", ex_valid); end
      tick();
      set_id(6, 5, 1, 1, 1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         #1; checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_stall got=%0b exp=0", ex_valid); end
         tick();
      end
      set_wb_front(); #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got=%0b exp=0", ex_valid); end
      tick();
      wb_valid = 0; #1;
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL raw_release got=%0b exp=1", ex_valid); end
      checks++; if (dut.cnt_all[5] !== 2'd0) begin errors++; $display("FAIL raw_cnt5 got=%0d exp=0", dut.cnt_all[5]); end
      tick();
      drain_all(); #1;
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL raw_drained got=%0d exp=0", inflight); end
   endtask

   task automatic test_capacity();
      idle();
      for (int i = 1; i <= 4; i++) begin
         set_id(i, 0, 0, 0, 0, 1, 0); #1;
         checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL cap_issue%0d got=%0b exp=1", i, ex_valid); end
         tick();
      end
      set_id(8, 0, 0, 0, 0, 1, 0); #1;
      checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin errors++; $display("FAIL cap_full got=%0b/%0b exp=0/0", ex_valid, id_ready); end
      checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL cap_inflight got=%0d exp=4", inflight); end
      tick();
      set_wb_front(); #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL cap_retire_cycle got=%0b exp=0", ex_valid); end
      tick();
      wb_valid = 0; #1;
      checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL cap_after_retire got=%0d exp=3", inflight); end
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL cap_fifth got=%0b exp=1", ex_valid); end
      tick();
      drain_all();
   endtask

   task automatic test_serial();
      idle();
      set_id(1, 0, 0, 0, 0, 1, 0); tick();
      set_id(2, 0, 0, 0, 0, 1, 0); tick();
      set_id(3, 0, 0, 0, 0, 1, 1); #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ser_wait got=%0b exp=0", ex_valid); end
      tick();
      set_wb_front(); #1;
      checks++; if (dut.state_q !== ISSUE_DRAIN) begin errors++; $display("FAIL ser_drain got=%0d exp=%0d", dut.state_q, ISSUE_DRAIN); end
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ser_drain_ev got=%0b exp=0", ex_valid); end
      tick();
      set_wb_front(); #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ser_drain_ev2 got=%0b exp=0", ex_valid); end
      tick();
      wb_valid = 0; #1;
      checks++; if (dut.state_q !== ISSUE_DRAIN || inflight !== 3'd0) begin errors++; $display("FAIL ser_drain_exit got=%0d/%0d exp=%0d/0", dut.state_q, inflight, ISSUE_DRAIN); end
      tick(); #1;
      checks++; if (dut.state_q !== ISSUE_RUN || ex_valid !== 1'b1) begin errors++; $display("FAIL ser_issue got=%0d/%0b exp=%0d/1", dut.state_q, ex_valid, ISSUE_RUN); end
      tick();
      set_id(4, 0, 0, 0, 0, 1, 0); #1;
      checks++; if (dut.state_q !== ISSUE_SOLO) begin errors++; $display("FAIL ser_solo got=%0d exp=%0d", dut.state_q, ISSUE_SOLO); end
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ser_solo_block got=%0b exp=0", ex_valid); end
      tick();
      set_wb_front(); #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ser_retire_cycle got=%0b exp=0", ex_valid); end
      tick();
      wb_valid = 0; #1;
      checks++; if (dut.state_q !== ISSUE_RUN || ex_valid !== 1'b1) begin errors++; $display("FAIL ser_back_run got=%0d/%0b exp=%0d/1", dut.state_q, ex_valid, ISSUE_RUN); end
      tick();
      drain_all();
   endtask

   task automatic test_simultaneous();
      idle();
      set_id(7, 0, 0, 0, 0, 1, 0); tick();
      set_id(7, 0, 0, 0, 0, 1, 0); set_wb_front(); #1;
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL sim_fire got=%0b exp=1", ex_valid); end
      tick();
      idle(); #1;
      checks++; if (dut.cnt_all[7] !== 2'd1) begin errors++; $display("FAIL sim_cnt7 got=%0d exp=1", dut.cnt_all[7]); end
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL sim_inflight got=%0d exp=1", inflight); end
      drain_all();
   endtask

   task automatic test_x0_sat();
      idle();
      for (int k = 0; k < 3; k++) begin
         set_id(0, 0, 1, 0, 1, 1, 0); #1;
         checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL x0_issue%0d got=%0b exp=1", k, ex_valid); end
         tick();
      end
      drain_all();
      for (int k = 0; k < 3; k++) begin set_id(3, 0, 0, 0, 0, 1, 0); tick(); end
      set_id(3, 0, 0, 0, 0, 1, 0); #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL sat_stall got=%0b exp=0", ex_valid); end
      checks++; if (dut.cnt_all[3] !== 2'd3 || inflight !== 3'd3) begin errors++; $display("FAIL sat_cnt got=%0d/%0d exp=3/3", dut.cnt_all[3], inflight); end
      set_id(4, 0, 0, 0, 0, 1, 0); #1;
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL sat_other got=%0b exp=1", ex_valid); end
      drain_all(); #1;
      checks++; if (dut.cnt_all[3] !== 2'd0) begin errors++; $display("FAIL sat_drain got=%0d exp=0", dut.cnt_all[3]); end
   endtask

   task automatic test_error_reset();
      idle(); wb_valid = 1; tick();
      wb_valid = 0; #1;
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got=%0b exp=1", sb_err); end
      tick(); tick(); #1;
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_hold got=%0b exp=1", sb_err); end
      rst = 1; tick(); rst = 0; #1;
      checks++; if (sb_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_clear got=%0b/%0b exp=0/0", sb_err, busy); end
      set_id(1, 0, 0, 0, 0, 1, 0); tick();
      id_valid = 0; wb_valid = 1; wb_rd = 5'd9; wb_gpr_we = 1; tick();
      idle(); #1;
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_cnt got=%0b exp=1", sb_err); end
      checks++; if (dut.cnt_all[9] !== 2'd0 || dut.cnt_all[1] !== 2'd1) begin errors++; $display("FAIL err_nowrap got=%0d/%0d exp=0/1", dut.cnt_all[9], dut.cnt_all[1]); end
      set_id(2, 0, 0, 0, 0, 1, 0); tick();
      idle(); rst = 1; tick(); rst = 0; #1;
      checks++; if (inflight !== 3'd0 || sb_err !== 1'b0 || dut.cnt_all[1] !== 2'd0 || dut.cnt_all[2] !== 2'd0)
         begin errors++; $display("FAIL mid_reset got=%0d/%0b/%0d/%0d exp=0/0/0/0", inflight, sb_err, dut.cnt_all[1], dut.cnt_all[2]); end
   endtask

   task automatic test_random();
      bit exp_stall;
      int r;
      idle(); rst = 1; tick(); rst = 0;
      for (int c = 0; c < 600; c++) begin
         id_valid = ($urandom % 4) != 0;
         id_rd = 5'($urandom % 8); id_rs1 = 5'($urandom % 8); id_rs2 = 5'($urandom % 8);
         id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); id_gpr_we = ($urandom % 4) != 0;
         id_serial = ($urandom % 12) == 0;
         ex_ready = ($urandom % 5) != 0;
         wb_rd = 5'($urandom % 8); wb_gpr_we = 1'($urandom); wb_valid = 0;
         if (q.size() != 0 && ($urandom % 3) == 0) set_wb_front();
         #1;
         exp_stall = m_stall();
         r = $urandom % 16;
         checks++; if (ex_valid !== (id_valid && !exp_stall)) begin errors++; $display("FAIL rnd_ex_valid c=%0d got=%0b exp=%0b", c, ex_valid, id_valid && !exp_stall); end
         checks++; if (id_ready !== (ex_ready && !exp_stall)) begin errors++; $display("FAIL rnd_id_ready c=%0d got=%0b exp=%0b", c, id_ready, ex_ready && !exp_stall); end
         checks++; if (int'(inflight) != m_infl) begin errors++; $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, inflight, m_infl); end
         checks++; if (busy !== (m_mode != 0 || m_infl != 0)) begin errors++; $display("FAIL rnd_busy c=%0d got=%0b", c, busy); end
         checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rnd_sb_err c=%0d got=%0b exp=%0b", c, sb_err, m_err); end
         checks++; if (dut.state_q !== m_state()) begin errors++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, dut.state_q, m_state()); end
         checks++; if (int'(dut.cnt_all[r]) != m_cnt[r]) begin errors++; $display("FAIL rnd_cnt c=%0d r=%0d got=%0d exp=%0d", c, r, dut.cnt_all[r], m_cnt[r]); end
         tick();
      end
      drain_all();
   endtask

   initial begin
      idle();
      rst = 1;
      tick();
      test_reset();
      test_raw();
      test_capacity();
      test_serial();
      test_simultaneous();
      test_x0_sat();
      test_error_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
